// File: rtl/uart_io_bridge.sv
// Bridges the core's in/out byte handshakes to an AXI4-Lite UART-Lite slave.
// TX/RX bytes are buffered in FIFOs while a polling FSM moves them over AXI with bounded retries.
module uart_io_bridge #(
  parameter int TX_DEPTH      = 16,
  parameter int RX_DEPTH      = 16,
  parameter int POLL_INTERVAL = 16,
  parameter int MAX_RETRY     = 3,
  localparam int TXLW = $clog2(TX_DEPTH + 1),
  localparam int RXLW = $clog2(RX_DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [TXLW-1:0] tx_level,
  output logic [RXLW-1:0] rx_level,
  output logic            err,
  output logic [3:0]      m_axi_awaddr,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [31:0]     m_axi_wdata,
  output logic [3:0]      m_axi_wstrb,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [3:0]      m_axi_araddr,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  input  logic [31:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TW   = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;

  typedef enum logic [2:0] {IDLE, STAT_AR, STAT_R, RX_AR, RX_R, TX_AWW, TX_B} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [RW-1:0]     retry_cnt;
  logic              stat_tx_full;

  logic [7:0]        tx_mem [TX_DEPTH];
  logic [TXAW-1:0]   tx_wr_ptr, tx_rd_ptr;
  logic [TXLW-1:0]   tx_count;
  logic              tx_push, tx_pop, tx_empty;

  logic [7:0]        rx_mem [RX_DEPTH];
  logic [RXAW-1:0]   rx_wr_ptr, rx_rd_ptr;
  logic [RXLW-1:0]   rx_count;
  logic              rx_push, rx_pop, rx_full;

  logic              r_ok, b_ok, retry_exhausted;
  logic              unused_rdata;

  assign tx_ready = (tx_count != TXLW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_level = tx_count;

  assign rx_valid = (rx_count != '0);
  assign rx_full  = (rx_count == RXLW'(RX_DEPTH));
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_data  = rx_mem[rx_rd_ptr];
  assign rx_level = rx_count;

  assign r_ok            = (m_axi_rresp == 2'b00);
  assign b_ok            = (m_axi_bresp == 2'b00);
  assign retry_exhausted = (retry_cnt == RETRY_LIMIT);

  // A TX byte leaves on an OKAY write response or when it is dropped after the last retry.
  assign tx_pop  = (state == TX_B) & m_axi_bvalid & (b_ok | retry_exhausted);
  assign rx_push = (state == RX_R) & m_axi_rvalid & r_ok & ~rx_full;

  assign m_axi_awaddr = ADDR_TX;
  assign m_axi_wstrb  = 4'b0001;
  assign m_axi_wdata  = {24'h0, tx_mem[tx_rd_ptr]};
  assign unused_rdata = ^m_axi_rdata[31:8];

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= m_axi_rdata[7:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TXAW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TXAW'(1);
      if (tx_push & ~tx_pop)      tx_count <= tx_count + TXLW'(1);
      else if (~tx_push & tx_pop) tx_count <= tx_count - TXLW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RXAW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RXAW'(1);
      if (rx_push & ~rx_pop)      rx_count <= rx_count + RXLW'(1);
      else if (~rx_push & rx_pop) rx_count <= rx_count - RXLW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      timer         <= TIMER_RELOAD;
      retry_cnt     <= '0;
      err           <= 1'b0;
      stat_tx_full  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= 4'h0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (timer == '0) begin
            timer <= TIMER_RELOAD;
            if (!tx_empty || !rx_full) begin
              state         <= STAT_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= ADDR_STAT;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STAT_AR, RX_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= (state == STAT_AR) ? STAT_R : RX_R;
          end
        end
        STAT_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (r_ok) begin
              retry_cnt    <= '0;
              stat_tx_full <= m_axi_rdata[3];
              // RX is served first so the UART's receive buffer cannot overrun.
              if (m_axi_rdata[0] && !rx_full) begin
                state         <= RX_AR;
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= ADDR_RX;
              end else if (!m_axi_rdata[3] && !tx_empty) begin
                state         <= TX_AWW;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else if (retry_exhausted) begin
              retry_cnt <= '0;
              err       <= 1'b1;
              state     <= IDLE;
            end else begin
              retry_cnt     <= retry_cnt + RW'(1);
              state         <= STAT_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= ADDR_STAT;
            end
          end
        end
        RX_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (r_ok || retry_exhausted) begin
              retry_cnt <= '0;
              if (!r_ok) err <= 1'b1;
              if (r_ok && !stat_tx_full && !tx_empty) begin
                state         <= TX_AWW;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              retry_cnt     <= retry_cnt + RW'(1);
              state         <= RX_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= ADDR_RX;
            end
          end
        end
        TX_AWW: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            state        <= TX_B;
            m_axi_bready <= 1'b1;
          end
        end
        TX_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (b_ok || retry_exhausted) begin
              retry_cnt <= '0;
              if (!b_ok) err <= 1'b1;
              state <= IDLE;
            end else begin
              retry_cnt     <= retry_cnt + RW'(1);
              state         <= TX_AWW;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed bench for uart_io_bridge: a small AXI4-Lite UART-Lite responder plus hand-computed expectations.
module tb_uart_io_bridge;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  tx_level;
  logic [2:0]  rx_level;
  logic        err;
  logic [3:0]  m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [3:0]  m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int errors = 0;
  int checks = 0;

  // Responder knobs and logs
  logic [7:0]  stat_val = 8'h00;
  logic [7:0]  rx_byte  = 8'h00;
  int          b_fail   = 0;
  int          aw_beats = 0;
  int          rx_reads = 0;
  int          addr_errs = 0;
  logic [31:0] tx_log[$];

  uart_io_bridge #(
    .TX_DEPTH(4), .RX_DEPTH(4), .POLL_INTERVAL(4), .MAX_RETRY(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLK);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_empty(input int max_cycles);
    for (int i = 0; i < max_cycles && tx_level != 0; i++) @(negedge CLK);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Slave model: handshakes are sampled at the rising edge, responses change on the falling edge.
  initial begin
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;
    logic [3:0]  ar_addr_q, aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    aw_got = 1'b0;
    w_got  = 1'b0;
    m_axi_arready = 1'b1;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 32'h0;
    m_axi_rresp   = 2'b00;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    forever begin
      @(posedge CLK);
      ar_hs     = m_axi_arvalid & m_axi_arready;
      ar_addr_q = m_axi_araddr;
      r_hs      = m_axi_rvalid & m_axi_rready;
      aw_hs     = m_axi_awvalid & m_axi_awready;
      aw_addr_q = m_axi_awaddr;
      w_hs      = m_axi_wvalid & m_axi_wready;
      w_data_q  = m_axi_wdata;
      w_strb_q  = m_axi_wstrb;
      b_hs      = m_axi_bvalid & m_axi_bready;
      @(negedge CLK);
      if (!RST_N) begin
        m_axi_rvalid = 1'b0;
        m_axi_bvalid = 1'b0;
        aw_got = 1'b0;
        w_got  = 1'b0;
      end else begin
        if (r_hs) m_axi_rvalid = 1'b0;
        if (ar_hs) begin
          m_axi_rvalid = 1'b1;
          m_axi_rresp  = 2'b00;
          if (ar_addr_q == 4'h8) m_axi_rdata = {24'h0, stat_val};
          else begin
            m_axi_rdata = {24'h0, rx_byte};
            rx_reads++;
            if (ar_addr_q != 4'h0) addr_errs++;
          end
        end
        if (b_hs) m_axi_bvalid = 1'b0;
        if (aw_hs) begin
          aw_beats++;
          aw_got = 1'b1;
          if (aw_addr_q != 4'h4) addr_errs++;
        end
        if (w_hs) begin
          w_got = 1'b1;
          tx_log.push_back(w_data_q);
          if (w_strb_q != 4'b0001) addr_errs++;
        end
        if (aw_got && w_got) begin
          aw_got = 1'b0;
          w_got  = 1'b0;
          m_axi_bvalid = 1'b1;
          if (b_fail > 0) begin
            m_axi_bresp = 2'b10;
            b_fail--;
          end else begin
            m_axi_bresp = 2'b00;
          end
        end
      end
    end
  end

  initial begin
    int beats0, log_base, reads0;
    RST_N    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_tx_level", tx_level, 0);
    checkOutput("rst_rx_level", rx_level, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 0);
    checkOutput("rst_readys", {m_axi_rready, m_axi_bready}, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    $display("[TB] in-order TX of three bytes");
    stat_val = 8'h08;
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    checkOutput("tx3_level", tx_level, 3);
    beats0   = aw_beats;
    log_base = tx_log.size();
    stat_val = 8'h00;
    wait_tx_empty(300);
    checkOutput("tx3_drained", tx_level, 0);
    checkOutput("tx3_beats", aw_beats - beats0, 3);
    for (int i = 0; i < 3; i++)
      checkOutput("tx3_wdata", log_at(log_base + i), 32'h41 + i);

    $display("[TB] single RX byte");
    rx_byte  = 8'h5A;
    reads0   = rx_reads;
    stat_val = 8'h01;
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge CLK);
    stat_val = 8'h00;
    checkOutput("rx_valid", rx_valid, 1);
    checkOutput("rx_data", rx_data, 8'h5A);
    checkOutput("rx_level1", rx_level, 1);
    checkOutput("rx_reads1", rx_reads - reads0, 1);
    @(negedge CLK);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    checkOutput("rx_level0", rx_level, 0);
    checkOutput("rx_valid0", rx_valid, 0);

    $display("[TB] TX FIFO full while UART reports full");
    stat_val = 8'h08;
    beats0   = aw_beats;
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i));
    checkOutput("full_tx_ready", tx_ready, 0);
    checkOutput("full_tx_level", tx_level, 4);
    applyStimulus(8'h99);
    checkOutput("full_extra_ignored", tx_level, 4);
    repeat (30) @(negedge CLK);
    checkOutput("full_no_aw", aw_beats - beats0, 0);
    log_base = tx_log.size();
    stat_val = 8'h00;
    wait_tx_empty(400);
    checkOutput("full_drained", tx_level, 0);
    checkOutput("full_log_size", tx_log.size() - log_base, 4);
    for (int i = 0; i < 4; i++)
      checkOutput("full_wdata", log_at(log_base + i), 32'h10 + i);

    $display("[TB] two SLVERR then OKAY");
    b_fail   = 2;
    beats0   = aw_beats;
    log_base = tx_log.size();
    applyStimulus(8'h55);
    wait_tx_empty(300);
    checkOutput("retry_drained", tx_level, 0);
    checkOutput("retry_beats", aw_beats - beats0, 3);
    checkOutput("retry_err", err, 0);
    checkOutput("retry_wdata", log_at(log_base + 2), 32'h55);

    $display("[TB] four SLVERR drops the byte");
    b_fail = 4;
    beats0 = aw_beats;
    applyStimulus(8'h77);
    wait_tx_empty(300);
    checkOutput("drop_drained", tx_level, 0);
    checkOutput("drop_beats", aw_beats - beats0, 4);
    checkOutput("drop_err", err, 1);
    checkOutput("drop_fail_used", b_fail, 0);
    repeat (20) @(negedge CLK);
    checkOutput("drop_no_more_aw", aw_beats - beats0, 4);

    $display("[TB] RX FIFO full blocks RX reads");
    rx_byte  = 8'h33;
    reads0   = rx_reads;
    stat_val = 8'h01;
    for (int i = 0; i < 300 && rx_level != 4; i++) @(negedge CLK);
    checkOutput("rxfull_level", rx_level, 4);
    checkOutput("rxfull_reads", rx_reads - reads0, 4);
    repeat (40) @(negedge CLK);
    checkOutput("rxfull_no_read", rx_reads - reads0, 4);
    checkOutput("rxfull_head", rx_data, 8'h33);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    for (int i = 0; i < 100 && rx_level != 4; i++) @(negedge CLK);
    checkOutput("rxfull_refill", rx_reads - reads0, 5);
    stat_val = 8'h00;
    repeat (20) @(negedge CLK);
    rx_ready = 1'b1;
    repeat (4) @(negedge CLK);
    rx_ready = 1'b0;
    checkOutput("rxfull_emptied", rx_level, 0);
    checkOutput("addr_strb_errs", addr_errs, 0);

    $display("[TB] reset during a write");
    stat_val = 8'h08;
    applyStimulus(8'h21);
    applyStimulus(8'h22);
    stat_val = 8'h00;
    for (int i = 0; i < 100 && !m_axi_awvalid; i++) @(negedge CLK);
    checkOutput("mid_awvalid_seen", m_axi_awvalid, 1);
    RST_N = 1'b0;
    #1;
    checkOutput("mid_awvalid", m_axi_awvalid, 0);
    checkOutput("mid_wvalid", m_axi_wvalid, 0);
    checkOutput("mid_tx_level", tx_level, 0);
    checkOutput("mid_rx_level", rx_level, 0);
    checkOutput("mid_tx_ready", tx_ready, 1);
    checkOutput("mid_err", err, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
